// File: rtl/fft_frame_sequencer_if.sv
// Stream channels around the FFT core: upstream samples, core data/config inputs,
// and the core output handshake that the sequencer only observes.
interface fft_frame_sequencer_if #(
    parameter int CFG_W = 16
);
    logic [31:0]      s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;

    logic [31:0]      fft_data_tdata;
    logic             fft_data_tvalid;
    logic             fft_data_tready;
    logic             fft_data_tlast;

    logic [CFG_W-1:0] fft_cfg_tdata;
    logic             fft_cfg_tvalid;
    logic             fft_cfg_tready;

    logic             fft_out_tvalid;
    logic             fft_out_tready;
    logic             fft_out_tlast;

    // Environment side: upstream source, FFT core and downstream sink.
    modport master (
        output s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready,
        input  fft_data_tdata, fft_data_tvalid, fft_data_tlast,
        output fft_data_tready,
        input  fft_cfg_tdata, fft_cfg_tvalid,
        output fft_cfg_tready,
        output fft_out_tvalid, fft_out_tready, fft_out_tlast
    );

    // Sequencer side.
    modport slave (
        input  s_axis_tdata, s_axis_tvalid,
        output s_axis_tready,
        output fft_data_tdata, fft_data_tvalid, fft_data_tlast,
        input  fft_data_tready,
        output fft_cfg_tdata, fft_cfg_tvalid,
        input  fft_cfg_tready,
        input  fft_out_tvalid, fft_out_tready, fft_out_tlast
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer in front of a streaming FFT core: issues config words on frame
// boundaries, frames the upstream stream with tlast and checks output alignment.
module fft_frame_sequencer #(
    parameter int               FRAME_LEN   = 1024,
    parameter int               CNT_W       = 10,
    parameter int               CFG_W       = 16,
    parameter logic [CFG_W-1:0] CFG_DEFAULT = CFG_W'(1)
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               enable,
    input  logic [CFG_W-1:0]   cfg_word,
    input  logic               cfg_update,
    input  logic               err_clr,
    fft_frame_sequencer_if.slave bus,
    output logic [15:0]        frames_in,
    output logic [15:0]        frames_out,
    output logic               busy,
    output logic               err_tlast
);

    typedef enum logic [1:0] {IDLE, CONFIG, STREAM} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t           state;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [CFG_W-1:0] cfg_shadow;
    logic [CFG_W-1:0] cfg_tdata_q;
    logic             cfg_pending;
    logic             cfg_tvalid_q;

    logic             streaming;
    logic             in_beat;
    logic             in_last;
    logic             cfg_fire;
    logic             out_beat;
    logic             out_err;
    logic [CFG_W-1:0] next_shadow;

    always_comb begin
        streaming   = (state == STREAM);
        in_beat     = streaming & bus.s_axis_tvalid & bus.fft_data_tready;
        in_last     = (sample_cnt == LAST_IDX);
        cfg_fire    = cfg_tvalid_q & bus.fft_cfg_tready;
        out_beat    = bus.fft_out_tvalid & bus.fft_out_tready;
        out_err     = out_beat & (bus.fft_out_tlast != (out_cnt == LAST_IDX));
        next_shadow = cfg_update ? cfg_word : cfg_shadow;
    end

    assign bus.fft_data_tdata  = bus.s_axis_tdata;
    assign bus.fft_data_tvalid = streaming & bus.s_axis_tvalid;
    assign bus.s_axis_tready   = streaming & bus.fft_data_tready;
    assign bus.fft_data_tlast  = streaming & in_last;
    assign bus.fft_cfg_tdata   = cfg_tdata_q;
    assign bus.fft_cfg_tvalid  = cfg_tvalid_q;

    assign busy = (state != IDLE) | (frames_in != frames_out);

    // The config word is snapshotted on entry to CONFIG so it stays stable while the
    // core stalls; an update that lands during the wait leaves the request pending.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            cfg_shadow   <= CFG_DEFAULT;
            cfg_tdata_q  <= CFG_DEFAULT;
            cfg_pending  <= 1'b1;
            cfg_tvalid_q <= 1'b0;
            sample_cnt   <= '0;
            frames_in    <= '0;
        end else begin
            if (cfg_update) begin
                cfg_shadow  <= cfg_word;
                cfg_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (cfg_pending) begin
                            state        <= CONFIG;
                            cfg_tvalid_q <= 1'b1;
                            cfg_tdata_q  <= next_shadow;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                CONFIG: begin
                    if (cfg_fire) begin
                        cfg_tvalid_q <= 1'b0;
                        cfg_pending  <= cfg_update | (cfg_shadow != cfg_tdata_q);
                        state        <= STREAM;
                    end
                end
                STREAM: begin
                    if (in_beat) begin
                        if (in_last) begin
                            sample_cnt <= '0;
                            frames_in  <= frames_in + 16'd1;
                            if (!enable) begin
                                state <= IDLE;
                            end else if (cfg_pending) begin
                                state        <= CONFIG;
                                cfg_tvalid_q <= 1'b1;
                                cfg_tdata_q  <= next_shadow;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output monitor follows the core's own tlast so one misaligned frame does not
    // poison every later one; a new error outranks a clear in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_cnt    <= '0;
            frames_out <= '0;
            err_tlast  <= 1'b0;
        end else begin
            if (out_beat) begin
                if (bus.fft_out_tlast) begin
                    out_cnt    <= '0;
                    frames_out <= frames_out + 16'd1;
                end else begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end
            if (out_err) begin
                err_tlast <= 1'b1;
            end else if (err_clr) begin
                err_tlast <= 1'b0;
            end
        end
    end

endmodule
